// File: rtl/oled_timer_pkg.sv
// Shared types and constants for the OLED multi-channel delay timer.
// Contents:
//   tmr_state_t    - per-channel state (idle, counting, expired)
//   DEF_CNT_W      - default tick count / load value width
//   DEF_PRE_W      - default prescaler divide width
//   MODE_ONESHOT   - stop after the first expiry
//   MODE_PERIODIC  - auto-reload and keep running after each expiry
package oled_timer_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_RUN  = 2'd1,
        TMR_DONE = 2'd2
    } tmr_state_t;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_PRE_W = 16;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/oled_timer_channel.sv
// One delay-timer channel: FSM, prescale counter, tick counter, outputs.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - start/restart strobe (latches load_val, pre_div, periodic)
//   stop        - abort strobe, wins over start
//   periodic    - mode sampled on start
//   load_val    - tick count N sampled on start
//   pre_div     - prescale value D sampled on start (tick every D+1 clks)
//   busy        - channel is counting
//   done        - sticky expiry level
//   expire_p    - one-clk expiry pulse
module oled_timer_channel
    import oled_timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load_val,
    input  logic [PRE_W-1:0] pre_div,
    output logic             busy,
    output logic             done,
    output logic             expire_p
);

    tmr_state_t       state_reg;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] tick_cnt_reg;
    logic [PRE_W-1:0] d_reg;
    logic [PRE_W-1:0] pre_cnt_reg;
    logic             mode_reg;

    // The final tick is the one that would bring the count up to N; expiring
    // on that tick (rather than a cycle later) places the pulse exactly
    // N*(D+1) clks after the start edge. N=0 expires on the first RUN clk.
    logic last_tick;
    assign last_tick = (n_reg == '0) ||
                       ((pre_cnt_reg == d_reg) && (tick_cnt_reg == n_reg - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= TMR_IDLE;
            n_reg        <= '0;
            tick_cnt_reg <= '0;
            d_reg        <= '0;
            pre_cnt_reg  <= '0;
            mode_reg     <= MODE_ONESHOT;
            busy         <= 1'b0;
            done         <= 1'b0;
            expire_p     <= 1'b0;
        end else begin
            expire_p <= 1'b0;
            if (stop) begin
                state_reg    <= TMR_IDLE;
                tick_cnt_reg <= '0;
                pre_cnt_reg  <= '0;
                busy         <= 1'b0;
                done         <= 1'b0;
            end else if (start) begin
                // Restart from any state; an interval in progress is dropped
                // without a pulse, including one that would expire this clk.
                state_reg    <= TMR_RUN;
                n_reg        <= load_val;
                d_reg        <= pre_div;
                mode_reg     <= periodic;
                tick_cnt_reg <= '0;
                pre_cnt_reg  <= '0;
                busy         <= 1'b1;
                done         <= 1'b0;
            end else begin
                case (state_reg)
                    TMR_RUN: begin
                        if (last_tick) begin
                            expire_p     <= 1'b1;
                            done         <= 1'b1;
                            tick_cnt_reg <= '0;
                            pre_cnt_reg  <= '0;
                            if (mode_reg == MODE_ONESHOT) begin
                                state_reg <= TMR_DONE;
                                busy      <= 1'b0;
                            end
                        end else if (pre_cnt_reg == d_reg) begin
                            pre_cnt_reg  <= '0;
                            tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
                        end else begin
                            pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
                        end
                    end
                    default: begin
                        // IDLE and DONE hold until the next start or stop.
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/oled_multi_delay_timer.sv
// Multi-channel prescaled delay timer for the OLED sequencers.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start/stop  - per-channel strobes, one clk wide (stop wins)
//   periodic    - per-channel mode (0 one-shot, 1 auto-reload)
//   load_val    - per-channel tick count, channel i at [i*CNT_W +: CNT_W]
//   pre_div     - shared prescale value, latched per channel on its start
//   busy, done, expire_p - per-channel registered status
//   any_busy    - OR of busy
module oled_multi_delay_timer
    import oled_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PRE_W  = DEF_PRE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] load_val,
    input  logic [PRE_W-1:0]        pre_div,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       expire_p,
    output logic                    any_busy
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            oled_timer_channel #(
                .CNT_W (CNT_W),
                .PRE_W (PRE_W)
            ) u_channel (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (start[gi]),
                .stop     (stop[gi]),
                .periodic (periodic[gi]),
                .load_val (load_val[gi*CNT_W +: CNT_W]),
                .pre_div  (pre_div),
                .busy     (busy[gi]),
                .done     (done[gi]),
                .expire_p (expire_p[gi])
            );
        end
    endgenerate

    assign any_busy = |busy;

endmodule

// File: tb/tb_oled_multi_delay_timer.sv
// Self-checking bench for oled_multi_delay_timer. Each task drives one
// scenario; expected expiry pulses (channel, clks after the start edge) are
// queued when the start is driven and popped as the DUT pulses.
module tb_oled_multi_delay_timer;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int PRE_W  = 16;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       stop;
    logic [NUM_CH-1:0]       periodic;
    logic [NUM_CH*CNT_W-1:0] load_val;
    logic [PRE_W-1:0]        pre_div;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH-1:0]       expire_p;
    logic                    any_busy;

    typedef struct packed {
        int ch;
        int rel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    oled_multi_delay_timer #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .PRE_W  (PRE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .load_val (load_val),
        .pre_div  (pre_div),
        .busy     (busy),
        .done     (done),
        .expire_p (expire_p),
        .any_busy (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next active edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input int n, input logic per);
        load_val[ch*CNT_W +: CNT_W] = n;
        periodic[ch] = per;
    endtask

    task automatic test_reset();
        int pulses;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({busy, done, expire_p, any_busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b expire_p=%b any_busy=%b, required all 0",
                     busy, done, expire_p, any_busy);
        end
        rst_n = 1'b1;
        step();
        // Long run aborted by reset at cycle 200.
        set_ch(0, 1000, 1'b0);
        pre_div = 0;
        start = 4'b0001;
        step();
        start = '0;
        for (int rel = 1; rel <= 200; rel++) step();
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun_busy: busy[0]=%b, required 1", busy[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, expire_p, any_busy} !== '0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b expire_p=%b any_busy=%b, required all 0",
                     busy, done, expire_p, any_busy);
        end
        step();
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int rel = 1; rel <= 1100; rel++) begin
            step();
            if (expire_p !== '0) pulses++;
        end
        checks++;
        if (pulses !== 0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: pulses=%0d busy[0]=%b after reset, required 0 and 0",
                     pulses, busy[0]);
        end
    endtask

    task automatic test_oneshot();
        exp_q.delete();
        set_ch(0, 5, 1'b0);
        pre_div = 3;
        start = 4'b0001;
        step();
        start = '0;
        exp_q.push_back('{ch: 0, rel: 20});
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_busy_k: busy[0]=%b, required 1", busy[0]);
        end
        for (int rel = 1; rel <= 30; rel++) begin
            step();
            checks++;
            if (busy[0] !== (rel < 20) || done[0] !== (rel >= 20)) begin
                errors++;
                $display("FAIL oneshot_status: k+%0d busy[0]=%b done[0]=%b, required %b %b",
                         rel, busy[0], done[0], rel < 20, rel >= 20);
            end
            for (int c = 0; c < NUM_CH; c++) if (expire_p[c]) begin
                checks++;
                if (exp_q.size() != 0 && exp_q[0].ch == c && exp_q[0].rel == rel) void'(exp_q.pop_front());
                else begin
                    errors++;
                    $display("FAIL oneshot_pulse: expire_p[%0d]=1 at k+%0d, required 0", c, rel);
                end
            end
            while (exp_q.size() != 0 && exp_q[0].rel <= rel) begin
                checks++;
                errors++;
                $display("FAIL oneshot_pulse: expire_p[%0d]=0 at k+%0d, required 1", exp_q[0].ch, exp_q[0].rel);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_periodic();
        exp_q.delete();
        set_ch(1, 3, 1'b1);
        pre_div = 1;
        start = 4'b0010;
        step();
        start = '0;
        exp_q.push_back('{ch: 1, rel: 6});
        exp_q.push_back('{ch: 1, rel: 12});
        for (int rel = 1; rel <= 24; rel++) begin
            step();
            checks++;
            if (busy[1] !== (rel < 14) || done[1] !== (rel >= 6 && rel < 14)) begin
                errors++;
                $display("FAIL periodic_status: k+%0d busy[1]=%b done[1]=%b, required %b %b",
                         rel, busy[1], done[1], rel < 14, rel >= 6 && rel < 14);
            end
            for (int c = 0; c < NUM_CH; c++) if (expire_p[c]) begin
                checks++;
                if (exp_q.size() != 0 && exp_q[0].ch == c && exp_q[0].rel == rel) void'(exp_q.pop_front());
                else begin
                    errors++;
                    $display("FAIL periodic_pulse: expire_p[%0d]=1 at k+%0d, required 0", c, rel);
                end
            end
            while (exp_q.size() != 0 && exp_q[0].rel <= rel) begin
                checks++;
                errors++;
                $display("FAIL periodic_pulse: expire_p[%0d]=0 at k+%0d, required 1", exp_q[0].ch, exp_q[0].rel);
                void'(exp_q.pop_front());
            end
            stop = (rel == 13) ? 4'b0010 : 4'b0000;
        end
    endtask

    task automatic test_boundaries();
        // N=0, D=7 one-shot on ch3, then periodic N=0 on ch2 stopped after 10 pulses.
        exp_q.delete();
        set_ch(3, 0, 1'b0);
        set_ch(2, 0, 1'b1);
        pre_div = 7;
        start = 4'b1000;
        step();
        start = 4'b0100;
        step();
        start = '0;
        // ch3 pulsed at k3+1 == k2; ch2 pulses at k2+1..k2+10.
        checks++;
        if (expire_p[3] !== 1'b1 || done[3] !== 1'b1 || busy[3] !== 1'b0) begin
            errors++;
            $display("FAIL n0_oneshot: expire_p[3]=%b done[3]=%b busy[3]=%b, required 1 1 0",
                     expire_p[3], done[3], busy[3]);
        end
        for (int r = 1; r <= 10; r++) exp_q.push_back('{ch: 2, rel: r});
        for (int rel = 1; rel <= 14; rel++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) if (expire_p[c]) begin
                checks++;
                if (exp_q.size() != 0 && exp_q[0].ch == c && exp_q[0].rel == rel) void'(exp_q.pop_front());
                else begin
                    errors++;
                    $display("FAIL n0_periodic_pulse: expire_p[%0d]=1 at k+%0d, required 0", c, rel);
                end
            end
            while (exp_q.size() != 0 && exp_q[0].rel <= rel) begin
                checks++;
                errors++;
                $display("FAIL n0_periodic_pulse: expire_p[%0d]=0 at k+%0d, required 1", exp_q[0].ch, exp_q[0].rel);
                void'(exp_q.pop_front());
            end
            stop = (rel == 10) ? 4'b0100 : 4'b0000;
        end
        // Restart ch2 at k+10 of a 16-clk interval: pulse only at k+26.
        exp_q.delete();
        set_ch(2, 4, 1'b0);
        pre_div = 3;
        start = 4'b0100;
        step();
        start = '0;
        exp_q.push_back('{ch: 2, rel: 26});
        for (int rel = 1; rel <= 30; rel++) begin
            step();
            checks++;
            if (busy[2] !== (rel < 26)) begin
                errors++;
                $display("FAIL restart_busy: k+%0d busy[2]=%b, required %b", rel, busy[2], rel < 26);
            end
            for (int c = 0; c < NUM_CH; c++) if (expire_p[c]) begin
                checks++;
                if (exp_q.size() != 0 && exp_q[0].ch == c && exp_q[0].rel == rel) void'(exp_q.pop_front());
                else begin
                    errors++;
                    $display("FAIL restart_pulse: expire_p[%0d]=1 at k+%0d, required 0", c, rel);
                end
            end
            while (exp_q.size() != 0 && exp_q[0].rel <= rel) begin
                checks++;
                errors++;
                $display("FAIL restart_pulse: expire_p[%0d]=0 at k+%0d, required 1", exp_q[0].ch, exp_q[0].rel);
                void'(exp_q.pop_front());
            end
            start = (rel == 9) ? 4'b0100 : 4'b0000;
        end
        // start+stop together while running ch1 -> IDLE, no pulse.
        exp_q.delete();
        set_ch(1, 10, 1'b0);
        pre_div = 0;
        start = 4'b0010;
        step();
        start = '0;
        for (int rel = 1; rel <= 15; rel++) begin
            step();
            checks++;
            if (busy[1] !== (rel < 4) || done[1] !== 1'b0 || expire_p[1] !== 1'b0) begin
                errors++;
                $display("FAIL start_stop: k+%0d busy[1]=%b done[1]=%b expire_p[1]=%b, required %b 0 0",
                         rel, busy[1], done[1], expire_p[1], rel < 4);
            end
            start = (rel == 3) ? 4'b0010 : 4'b0000;
            stop  = (rel == 3) ? 4'b0010 : 4'b0000;
        end
    endtask

    task automatic test_concurrency();
        exp_q.delete();
        set_ch(0, 4, 1'b0);
        set_ch(1, 8, 1'b0);
        set_ch(2, 2, 1'b0);
        set_ch(3, 6, 1'b0);
        pre_div = 0;
        start = 4'b1111;
        step();
        start = '0;
        exp_q.push_back('{ch: 2, rel: 2});
        exp_q.push_back('{ch: 0, rel: 4});
        exp_q.push_back('{ch: 3, rel: 6});
        exp_q.push_back('{ch: 1, rel: 8});
        for (int rel = 1; rel <= 12; rel++) begin
            step();
            checks++;
            if (any_busy !== (rel < 8)) begin
                errors++;
                $display("FAIL concurrency_any_busy: k+%0d any_busy=%b, required %b", rel, any_busy, rel < 8);
            end
            for (int c = 0; c < NUM_CH; c++) if (expire_p[c]) begin
                checks++;
                if (exp_q.size() != 0 && exp_q[0].ch == c && exp_q[0].rel == rel) void'(exp_q.pop_front());
                else begin
                    errors++;
                    $display("FAIL concurrency_pulse: expire_p[%0d]=1 at k+%0d, required 0", c, rel);
                end
            end
            while (exp_q.size() != 0 && exp_q[0].rel <= rel) begin
                checks++;
                errors++;
                $display("FAIL concurrency_pulse: expire_p[%0d]=0 at k+%0d, required 1", exp_q[0].ch, exp_q[0].rel);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_latching();
        // First pass: N=5,D=1 (pulse at k+10), values changed mid-run.
        // Second pass: restart picks up N=2,D=0 (pulse at k+2).
        for (int pass = 0; pass < 2; pass++) begin
            exp_q.delete();
            if (pass == 0) begin
                set_ch(0, 5, 1'b0);
                pre_div = 1;
            end
            start = 4'b0001;
            step();
            start = '0;
            exp_q.push_back('{ch: 0, rel: (pass == 0) ? 10 : 2});
            for (int rel = 1; rel <= 14; rel++) begin
                step();
                for (int c = 0; c < NUM_CH; c++) if (expire_p[c]) begin
                    checks++;
                    if (exp_q.size() != 0 && exp_q[0].ch == c && exp_q[0].rel == rel) void'(exp_q.pop_front());
                    else begin
                        errors++;
                        $display("FAIL latching_pulse: pass %0d expire_p[%0d]=1 at k+%0d, required 0", pass, c, rel);
                    end
                end
                while (exp_q.size() != 0 && exp_q[0].rel <= rel) begin
                    checks++;
                    errors++;
                    $display("FAIL latching_pulse: pass %0d expire_p[%0d]=0 at k+%0d, required 1",
                             pass, exp_q[0].ch, exp_q[0].rel);
                    void'(exp_q.pop_front());
                end
                if (pass == 0 && rel == 3) begin
                    set_ch(0, 2, 1'b0);
                    pre_div = 0;
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = '0;
        stop     = '0;
        periodic = '0;
        load_val = '0;
        pre_div  = '0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_boundaries();
        test_concurrency();
        test_latching();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
